// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch / prefetch queue.
package fetch_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH    = 5;
  localparam int unsigned DEF_INSTRUCTION_SIZE = 32;
  localparam int unsigned PC_W                 = DEF_ADDRESS_WIDTH + 1;

  typedef struct packed {
    logic [PC_W-1:0]                 pc;
    logic [DEF_INSTRUCTION_SIZE-1:0] instruction;
  } fetch_entry_t;

  localparam logic [DEF_INSTRUCTION_SIZE-1:0] NOP = '0;

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with count and head output.
// A flush takes priority over push and pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch stage: owns the fetch PC, issues sequential reads to a 1-cycle
// synchronous instruction memory and queues {pc, instruction} for decode.
module inst_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
  parameter int unsigned INSTRUCTION_SIZE = DEF_INSTRUCTION_SIZE,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [ADDRESS_WIDTH:0]      imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        redirect_valid,
  input  logic [ADDRESS_WIDTH:0]      redirect_pc,
  output logic                        out_valid,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic [ADDRESS_WIDTH:0]      out_pc,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int unsigned PCW     = ADDRESS_WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = PCW + INSTRUCTION_SIZE;

  logic [PCW-1:0]     r_fetch_pc;
  logic               r_inflight;
  logic [PCW-1:0]     r_inflight_pc;

  logic [CNT_W-1:0]   w_count;
  logic [CNT_W:0]     w_committed;
  logic               w_credit;
  logic               w_req;
  logic               w_valid;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head_entry;

  // Credit counts queued plus in-flight words; a same-cycle pop gives no credit.
  assign w_committed = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
  assign w_credit    = (w_committed < (CNT_W+1)'(DEPTH));
  assign w_req       = !rst && !redirect_valid && w_credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_req) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  assign w_push_entry = {r_inflight_pc, imem_rdata};
  assign w_valid      = (w_count != '0);
  assign w_pop        = w_valid && out_ready;

  // Redirect flushes the queue, dropping both the response and the pop of this cycle.
  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (redirect_valid),
    .i_push  (r_inflight),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head_entry),
    .o_count (w_count)
  );

  assign imem_req        = w_req;
  assign imem_addr       = r_fetch_pc;
  assign out_valid       = w_valid;
  assign occupancy       = w_count;
  assign out_pc          = w_valid ? w_head_entry[ENTRY_W-1 -: PCW] : '0;
  assign out_instruction = w_valid ? w_head_entry[INSTRUCTION_SIZE-1:0]
                                   : INSTRUCTION_SIZE'(NOP);

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue against a 1-cycle synchronous memory
// whose word k holds 32'h1000_0000 + k.
module tb_inst_prefetch_queue;
  import fetch_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [5:0]  out_pc;
  logic        out_ready;
  logic [2:0]  occupancy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= BASE + 32'(imem_addr);
  end

  inst_prefetch_queue #(
    .ADDRESS_WIDTH    (5),
    .INSTRUCTION_SIZE (32),
    .DEPTH            (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .occupancy       (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input int unsigned pc);
    fetch_entry_t e;
    e.pc          = 6'(pc);
    e.instruction = BASE + 32'(e.pc);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_pc"}, 64'(out_pc), 64'(e.pc));
    chk({tag, "_instr"}, 64'(out_instruction), 64'(e.instruction));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick(); tick();
    chk_empty("rst");
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_instr", 64'(out_instruction), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);

    // Reset release: out_valid in cycle 3, then one instruction per cycle
    rst = 1'b0; #1;
    chk("t1_c1_req", 64'(imem_req), 64'd1);
    chk("t1_c1_addr", 64'(imem_addr), 64'd0);
    tick();
    chk("t1_c2_valid", 64'(out_valid), 64'd0);
    chk("t1_c2_addr", 64'(imem_addr), 64'd1);
    tick();
    chk_head("t1_c3", 0);
    chk("t1_c3_occ", 64'(occupancy), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_head($sformatf("t1_seq%0d", k), k);
    end

    // Back-pressure: saturate at DEPTH, then drain without loss
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_c5_occ", 64'(occupancy), 64'd3);
    chk("t2_c5_req", 64'(imem_req), 64'd0);
    chk("t2_c5_addr", 64'(imem_addr), 64'd4);
    tick();
    chk("t2_c6_occ", 64'(occupancy), 64'd4);
    chk("t2_c6_req", 64'(imem_req), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_c10_occ", 64'(occupancy), 64'd4);
    chk_head("t2_c10", 0);
    out_ready = 1'b1;
    tick();
    chk_head("t2_c11", 1);
    chk("t2_c11_occ", 64'(occupancy), 64'd3);
    chk("t2_c11_req", 64'(imem_req), 64'd1);
    chk("t2_c11_addr", 64'(imem_addr), 64'd4);
    tick();
    chk_head("t2_c12", 2);
    chk("t2_c12_occ", 64'(occupancy), 64'd2);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk_head($sformatf("t2_seq%0d", k), k);
    end

    // Redirect with 3 queued and one in flight
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_pre_occ", 64'(occupancy), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 6'd17; #1;
    chk("t3_redir_req", 64'(imem_req), 64'd0);
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1; #1;
    chk_empty("t3_n1");
    chk("t3_n1_req", 64'(imem_req), 64'd1);
    chk("t3_n1_addr", 64'(imem_addr), 64'd17);
    tick();
    chk("t3_n2_valid", 64'(out_valid), 64'd0);
    tick(); chk_head("t3_n3", 17);
    tick(); chk_head("t3_n4", 18);
    tick(); chk_head("t3_n5", 19);

    // Redirect coinciding with a consumer pop
    redirect_valid = 1'b1; redirect_pc = 6'd40;
    tick();
    redirect_valid = 1'b0; #1;
    chk_empty("t4_n1");
    chk("t4_n1_addr", 64'(imem_addr), 64'd40);
    tick(); tick();
    chk_head("t4_n3", 40);
    tick(); chk_head("t4_n4", 41);

    // PC wrap 62,63,0,1
    redirect_valid = 1'b1; redirect_pc = 6'd62;
    tick();
    redirect_valid = 1'b0; #1;
    chk("t5_n1_addr", 64'(imem_addr), 64'd62);
    tick();
    chk("t5_n2_addr", 64'(imem_addr), 64'd63);
    tick();
    chk_head("t5_n3", 62);
    chk("t5_n3_addr", 64'(imem_addr), 64'd0);
    tick(); chk_head("t5_n4", 63);
    tick(); chk_head("t5_n5", 0);
    tick(); chk_head("t5_n6", 1);

    // Mid-stream reset with 2 queued; a simultaneous redirect loses to reset
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_pre_occ", 64'(occupancy), 64'd2);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'd20; #1;
    chk("t6_rst_req", 64'(imem_req), 64'd0);
    tick();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; #1;
    chk_empty("t6_n1");
    chk("t6_n1_req", 64'(imem_req), 64'd1);
    chk("t6_n1_addr", 64'(imem_addr), 64'd0);
    tick();
    chk("t6_n2_valid", 64'(out_valid), 64'd0);
    tick(); chk_head("t6_n3", 0);
    tick(); chk_head("t6_n4", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
